// File: rtl/serial_adder.sv
// serial_adder: multi-cycle adder processing DIGIT bits per clock through one slice and a carry register.
// Define SERIAL_ADDER_SUB_EN to add a sub port that turns the operation into a + ~b + 1.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             overflow
);
  localparam int D  = WIDTH / DIGIT;
  localparam int CW = D > 1 ? $clog2(D) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, r_q, r_d, s_q, s_d, r_shift;
  logic [CW-1:0] cnt_q, cnt_d;
  logic cy_q, cy_d, co_q, co_d, ov_q, ov_d;
  logic [DIGIT:0] slice;
  logic accept, run, last, fin, b_inv, c_init;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  end
  always_comb begin
    run     = state_q == RUN;
    accept  = start && !run;
    last    = cnt_q == CW'(D - 1);
    state_d = accept ? RUN : run ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    busy     = state_q == RUN;
    done     = state_q == DONE;
    s        = s_q;
    c_out    = co_q;
    overflow = ov_q;
  end
`ifdef SERIAL_ADDER_SUB_EN
  assign b_inv  = sub;
  assign c_init = sub | c_in;
`else
  assign b_inv  = 1'b0;
  assign c_init = c_in;
`endif
  // Subtraction is folded into the latch: B is stored inverted and the carry forced to 1.
  always_comb begin
    slice   = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + (DIGIT+1)'(cy_q);
    r_shift = (r_q >> DIGIT) | (WIDTH'(slice[DIGIT-1:0]) << (WIDTH - DIGIT));
    fin     = run && last;
    a_d     = accept ? a : run ? a_q >> DIGIT : a_q;
    b_d     = accept ? b ^ {WIDTH{b_inv}} : run ? b_q >> DIGIT : b_q;
    cy_d    = accept ? c_init : run ? slice[DIGIT] : cy_q;
    cnt_d   = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    r_d     = accept ? '0 : run ? r_shift : r_q;
    s_d     = fin ? r_shift : s_q;
    co_d    = fin ? slice[DIGIT] : co_q;
    // Carry into the top bit recovered from the slice's MSB sum bit.
    ov_d    = fin ? slice[DIGIT] ^ slice[DIGIT-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1] : ov_q;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_q   <= '0;
      b_q   <= '0;
      r_q   <= '0;
      s_q   <= '0;
      cnt_q <= '0;
      cy_q  <= 1'b0;
      co_q  <= 1'b0;
      ov_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      r_q   <= r_d;
      s_q   <= s_d;
      cnt_q <= cnt_d;
      cy_q  <= cy_d;
      co_q  <= co_d;
      ov_q  <= ov_d;
    end
  end
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: random and directed operations on DIGIT=1 and DIGIT=4 instances against an arithmetic model.
module tb_serial_adder;
  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_EN
  localparam bit HAS_SUB = 1'b1;
`else
  localparam bit HAS_SUB = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, start4 = 1'b0, cin = 1'b0, sub = 1'b0;
  logic [W-1:0] a = '0, b = '0, nx, ny, s1, s4;
  logic nci, busy1, done1, c1, ov1, busy4, done4, c4, ov4;
  logic [W+1:0] exp1, exp4;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  serial_adder #(.WIDTH(W), .DIGIT(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .c_in(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy1), .done(done1), .s(s1), .c_out(c1), .overflow(ov1));
  serial_adder #(.WIDTH(W), .DIGIT(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a), .b(b), .c_in(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .busy(busy4), .done(done4), .s(s4), .c_out(c4), .overflow(ov4));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [W+1:0] model(input logic [W-1:0] x, y, input logic ci, sb);
    logic [W-1:0] yy;
    logic [W:0] f;
    logic ov;
    yy = sb ? ~y : y;
    f  = {1'b0, x} + {1'b0, yy} + (W+1)'(sb ? 1'b1 : ci);
    ov = (x[W-1] == yy[W-1]) && (f[W-1] != x[W-1]);
    return {ov, f[W], f[W-1:0]};
  endfunction
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic check_zero(input string tag);
    check({tag, "_busy1"}, busy1, 0);
    check({tag, "_done1"}, done1, 0);
    check({tag, "_res1"}, {ov1, c1, s1}, 0);
    check({tag, "_busy4"}, busy4, 0);
    check({tag, "_done4"}, done4, 0);
    check({tag, "_res4"}, {ov4, c4, s4}, 0);
  endtask
  // k counts edges since the accepting edge; outputs must hold old values until k == D
  task automatic op(input logic [W-1:0] x, y, input logic ci, sb, both, poke, chain, pre);
    logic [W+1:0] m;
    m = model(x, y, ci, sb);
    if (!pre) begin
      a = x; b = y; cin = ci; sub = sb; start = 1'b1; start4 = both;
      tick();
    end
    start = 1'b0; start4 = 1'b0;
    for (int k = 0; k < (chain ? 9 : 10); k++) begin
      check("busy1", busy1, k < 8);
      check("done1", done1, k == 8);
      check("res1", {ov1, c1, s1}, k < 8 ? exp1 : m);
      if (both) begin
        check("busy4", busy4, k < 2);
        check("done4", done4, k == 2);
        check("res4", {ov4, c4, s4}, k < 2 ? exp4 : m);
      end
      if (poke && k == 3) begin
        a = ~x; b = ~y; cin = ~ci; start = 1'b1;
      end else if (chain && k == 8) begin
        a = nx; b = ny; cin = nci; start = 1'b1;
      end else start = 1'b0;
      tick();
    end
    exp1 = m;
    if (both) exp4 = m;
  endtask
  initial begin
    tick(); tick();
    check_zero("rst");
    reset = 1'b0;
    exp1 = '0; exp4 = '0;
    op(8'h5A, 8'h33, 1'b0, 1'b0, 1, 0, 0, 0);
    op(8'hFF, 8'h01, 1'b0, 1'b0, 1, 0, 0, 0);
    op(8'h7F, 8'h00, 1'b1, 1'b0, 1, 0, 0, 0);
    op(8'hFF, 8'hFF, 1'b1, 1'b0, 1, 0, 0, 0);
    op(8'h80, 8'h80, 1'b0, 1'b0, 1, 0, 0, 0);
    if (HAS_SUB) begin
      op(8'h10, 8'h20, 1'b0, 1'b1, 1, 0, 0, 0);
      op(8'h20, 8'h10, 1'b0, 1'b1, 1, 0, 0, 0);
    end
    op(8'h12, 8'h34, 1'b0, 1'b0, 0, 1, 0, 0);
    nx = 8'h3C; ny = 8'h4D; nci = 1'b1;
    op(8'hA5, 8'h5A, 1'b1, 1'b0, 0, 0, 1, 0);
    op(nx, ny, nci, 1'b0, 0, 0, 0, 1);
    repeat (20) op(W'($urandom), W'($urandom), 1'($urandom), HAS_SUB ? 1'($urandom) : 1'b0, 1, 0, 0, 0);
    a = 8'hC3; b = 8'h5E; cin = 1'b1; sub = 1'b0; start = 1'b1; start4 = 1'b0;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    #2 reset = 1'b1;
    #1 check("rst_busy1", busy1, 0);
    check("rst_done1", done1, 0);
    check("rst_res1", {ov1, c1, s1}, 0);
    tick();
    reset = 1'b0;
    for (int k = 0; k < 10; k++) begin
      check("post_rst_done1", done1, 0);
      check("post_rst_busy1", busy1, 0);
      tick();
    end
    check_zero("post_rst");
    exp1 = '0; exp4 = '0;
    op(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
